// File: rtl/dmem_access_arbiter.sv
// Two-port round-robin arbiter that splits byte/half/word loads and stores
// into little-endian byte accesses on a single synchronous byte-wide memory.
module dmem_access_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [5:0]          req_ctl,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [63:0]         req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        cnt_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [2:0]        ctl_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       asm_r;
    logic [1:0]        rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_re_r;
    logic              mem_we_r;
    logic [7:0]        mem_wdata_r;

    logic              grant_any_s;
    logic              grant_port_s;
    logic [1:0]        req_ready_s;
    logic [2:0]        sel_ctl_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic [31:0]       asm_nxt_s;
    logic [1:0]        cnt_nxt_s;

    // Index of the final byte of a transaction (N-1).
    function automatic logic [1:0] last_idx(input logic [2:0] ctl);
        case (ctl)
            3'b000, 3'b011, 3'b101: last_idx = 2'd0;
            3'b001, 3'b100, 3'b110: last_idx = 2'd1;
            default:                last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic is_store(input logic [2:0] ctl);
        is_store = ctl[2] & (ctl[1] | ctl[0]);
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = w[7:0];
            2'd1:    byte_of = w[15:8];
            2'd2:    byte_of = w[23:16];
            default: byte_of = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        put_byte = r;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] ctl, input logic [31:0] a);
        case (ctl)
            3'b000:  extend = {{24{a[7]}}, a[7:0]};
            3'b001:  extend = {{16{a[15]}}, a[15:0]};
            3'b010:  extend = a;
            3'b011:  extend = {24'h000000, a[7:0]};
            3'b100:  extend = {16'h0000, a[15:0]};
            default: extend = 32'h0000_0000;
        endcase
    endfunction

    // Round-robin grant decision; only meaningful while idle and out of reset.
    always_comb begin
        grant_any_s  = 1'b0;
        grant_port_s = 1'b0;
        if ((state_r == ST_IDLE) && rst_n) begin
            case (req_valid)
                2'b01: begin
                    grant_any_s  = 1'b1;
                    grant_port_s = 1'b0;
                end
                2'b10: begin
                    grant_any_s  = 1'b1;
                    grant_port_s = 1'b1;
                end
                2'b11: begin
                    grant_any_s  = 1'b1;
                    grant_port_s = ~last_grant_r;
                end
                default: begin
                    grant_any_s  = 1'b0;
                    grant_port_s = 1'b0;
                end
            endcase
        end else begin
            grant_any_s  = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    // Ready strobe and the granted port's request fields.
    always_comb begin
        req_ready_s = 2'b00;
        if (grant_any_s) begin
            req_ready_s = grant_port_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
        sel_ctl_s   = grant_port_s ? req_ctl[5:3] : req_ctl[2:0];
        sel_addr_s  = grant_port_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata_s = grant_port_s ? req_wdata[63:32] : req_wdata[31:0];
        cnt_nxt_s   = cnt_r + 2'd1;
    end

    // Load assembly: read data arrives one cycle after its strobe, so byte k-1 lands in cycle k.
    always_comb begin
        asm_nxt_s = asm_r;
        if ((state_r == ST_ACCESS) && !is_store(ctl_r) && (cnt_r != 2'd0)) begin
            asm_nxt_s = put_byte(asm_r, cnt_r - 2'd1, mem_rdata);
        end else if (state_r == ST_DRAIN) begin
            asm_nxt_s = put_byte(asm_r, last_idx(ctl_r), mem_rdata);
        end else begin
            asm_nxt_s = asm_r;
        end
    end

    // Transaction FSM with registered memory strobes and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 2'd0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            ctl_r        <= 3'd0;
            addr_r       <= '0;
            wdata_r      <= 32'h0000_0000;
            asm_r        <= 32'h0000_0000;
            rsp_valid_r  <= 2'b00;
            rsp_rdata_r  <= 32'h0000_0000;
            mem_addr_r   <= '0;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        state_r      <= ST_ACCESS;
                        cnt_r        <= 2'd0;
                        owner_r      <= grant_port_s;
                        last_grant_r <= grant_port_s;
                        ctl_r        <= sel_ctl_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        mem_addr_r   <= sel_addr_s;
                        mem_we_r     <= is_store(sel_ctl_s);
                        mem_re_r     <= ~is_store(sel_ctl_s);
                        mem_wdata_r  <= is_store(sel_ctl_s) ? sel_wdata_s[7:0] : 8'h00;
                    end else begin
                        mem_re_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    asm_r <= asm_nxt_s;
                    if (cnt_r == last_idx(ctl_r)) begin
                        mem_re_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        if (is_store(ctl_r)) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else begin
                        cnt_r       <= cnt_nxt_s;
                        mem_addr_r  <= addr_r + ADDR_W'(cnt_nxt_s);
                        mem_wdata_r <= is_store(ctl_r) ? byte_of(wdata_r, cnt_nxt_s) : 8'h00;
                    end
                end
                ST_DRAIN: begin
                    asm_r       <= asm_nxt_s;
                    rsp_rdata_r <= extend(ctl_r, asm_nxt_s);
                    rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_r <= 2'b00;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 2'b00;
                    mem_re_r    <= 1'b0;
                    mem_we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Shares one byte-wide, synchronous data-memory port between two load/store requesters (port 0 = core LSU, port 1 = DMA/debug).
- Round-robin arbitration; one transaction in flight at a time.
- Each LB/LH/LW/LBU/LHU/SB/SH/SW transaction is split into 1, 2 or 4 little-endian byte accesses.
- Load results are assembled, then sign- or zero-extended.

Parameters:
ADDR_W, 10, byte-address width; memory is 2^ADDR_W bytes; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = port i)
req_ready  out  2  per-requester accept strobe
req_ctl  in  6  3 bits per port: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
req_addr  in  2*ADDR_W  per-port byte base address
req_wdata  in  64  per-port store data (32 bits each; low bytes used for SB/SH)
rsp_valid  out  2  per-port one-cycle completion pulse
rsp_rdata  out  32  extended load data, shared, qualified by rsp_valid
mem_addr  out  ADDR_W  byte address to memory
mem_re  out  1  byte read strobe; mem_rdata valid the following cycle
mem_we  out  1  byte write strobe
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte (1-cycle latency after mem_re)

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; req_ready, rsp_valid, mem_re, mem_we all 0; mem_addr, mem_wdata, rsp_rdata 0; last_grant=1 so port 0 wins the first conflict.
- Reset mid-transaction: transaction aborted, no rsp_valid, no further mem strobes. Bytes already written stay written.
- Request protocol: requester holds req_valid, ctl, addr, wdata stable until it sees req_ready=1.
  - req_ready is a 1-cycle strobe, asserted only in IDLE, for at most one port.
  - Accept occurs on that edge; ctl, addr, wdata and owner are latched.
- Arbitration in IDLE:
  - One port valid: grant it.
  - Both valid: grant !last_grant; last_grant updates on every grant.
  - Neither valid: stay IDLE.
- Byte count N: 1 for ctl 000/011/101; 2 for 001/100/110; 4 for 010/111.
- FSM states: IDLE -> ACCESS -> (DRAIN, loads only) -> RESP -> IDLE.
- ACCESS, cycle k = 0..N-1:
  - mem_addr = base+k (wrapping).
  - Stores: mem_we=1, mem_wdata = wdata byte k.
  - Loads: mem_re=1; for k>0, capture mem_rdata into assembly byte k-1.
  - After k=N-1: stores go to RESP, loads go to DRAIN.
- DRAIN: mem_re=0; capture mem_rdata into byte N-1.
- RESP: rsp_valid[owner]=1 for exactly one cycle, then IDLE.
  - rsp_rdata for loads: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unmodified.
  - rsp_rdata for stores: 0. rsp_rdata is held until the next RESP.
- Latency, counted from the accept edge to the rsp_valid cycle inclusive:
  - Store: N+1 cycles.
  - Load: N+2 cycles.
  - Next accept is possible in the cycle after RESP.
- No backpressure on responses; requesters must take rsp_valid when pulsed.
- No alignment check. Misaligned accesses proceed byte-wise; addresses wrap at 2^ADDR_W-1 -> 0.
- mem_re and mem_we are never both 1. No mem strobe in IDLE, DRAIN or RESP.
- A new request from the owner arriving during RESP is not accepted until IDLE.

Test Plan:
- SW then LW, port 0: SW addr 0x010 data 0xDEADBEEF -> bytes EF,BE,AD,DE written to 0x010..0x013; rsp_valid[0] 5 cycles after accept. LW 0x010 -> rsp_rdata 0xDEADBEEF, 6 cycles after accept.
- Extension: byte 0x020 = 0x80. LB -> 0xFFFFFF80; LBU -> 0x00000080. Halfword 0x030 = 0x8001: LH -> 0xFFFF8001; LHU -> 0x00008001.
- Conflict: both ports valid in the same cycle after reset -> port 0 granted first, then port 1. Repeat with both held valid -> grants alternate 1,0,1...; no mem_re/mem_we overlap between transactions.
- Wrap: SH addr 0x3FF, ADDR_W=10, data 0x1234 -> 0x34 written at 0x3FF, 0x12 at 0x000. LHU 0x3FF -> 0x00001234.
- Sub-word store: SB 0x041 data 0xAAAAAA55 to a word at 0x040 pre-filled with 0x00000000 -> LW 0x040 returns 0x00005500.
- Reset mid-op: rst_n=0 during ACCESS k=1 of an SW -> no rsp_valid; mem_we=0 from the next cycle; after release a new LW is accepted and completes normally.
